pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. Generates per-stage enable and flush strobes for the IF_ID, ID_EX, EX_MEM and MEM_WB registers and the PC enable. Handles data-memory wait, load-use hazards, taken-branch redirects and halt draining. Sits beside the datapath and is driven by cache hit signals, hazard fields and the EX_MEM halt bit.

---
 rtl/pipeline_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: per-stage enables/flushes, PC enable, halt drain.
// Optional performance counters are enabled with `define PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl #(
    parameter int DMEM_TIMEOUT = 1024,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dreq,
    input  logic             mem_halt,
    input  logic             ex_load,
    input  logic [4:0]       ex_wsel,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_redirect,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic             mem_timeout
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int WC_W = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(DMEM_TIMEOUT);

    typedef enum logic [2:0] {
        START,
        RUN,
        MEM_WAIT,
        HALT_DRAIN,
        HALTED
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
    } ctl_t;

    state_t          state, state_nxt;
    ctl_t            ctl;
    logic [WC_W-1:0] wait_cnt, wait_nxt;
    logic            eval_run, skip_mem, act_redirect;
    logic            load_use, dmiss;

    assign load_use = ex_load && (ex_wsel != 5'd0) &&
                      ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));
    assign dmiss    = mem_dreq && !dhit;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= START;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_nxt;
            mem_timeout <= mem_timeout || (wait_nxt == WAIT_MAX);
            halted      <= halted || (state_nxt == HALTED);
        end
    end

    always_comb begin
        state_nxt    = state;
        ctl          = '0;
        wait_nxt     = wait_cnt;
        eval_run     = 1'b0;
        skip_mem     = 1'b0;
        act_redirect = 1'b0;

        case (state)
            START:    state_nxt = RUN;
            RUN:      eval_run = 1'b1;
            MEM_WAIT: begin
                if (!dhit) begin
                    ctl.memwb_flush = 1'b1;
                    if (wait_cnt != WAIT_MAX) wait_nxt = wait_cnt + WC_W'(1);
                end else begin
                    eval_run  = 1'b1;
                    skip_mem  = 1'b1;
                    wait_nxt  = '0;
                    state_nxt = RUN;
                end
            end
            HALT_DRAIN: begin
                ctl.memwb_en    = 1'b1;
                ctl.ifid_flush  = 1'b1;
                ctl.idex_flush  = 1'b1;
                ctl.exmem_flush = 1'b1;
                state_nxt       = HALTED;
            end
            HALTED:   state_nxt = HALTED;
            default:  state_nxt = START;
        endcase

        // Priority chain shared by RUN and the data-hit exit of MEM_WAIT
        if (eval_run) begin
            if (!skip_mem && mem_halt && !dmiss) begin
                ctl.memwb_en    = 1'b1;
                ctl.ifid_flush  = 1'b1;
                ctl.idex_flush  = 1'b1;
                ctl.exmem_flush = 1'b1;
                state_nxt       = HALT_DRAIN;
            end else if (!skip_mem && dmiss) begin
                ctl.memwb_flush = 1'b1;
                state_nxt       = MEM_WAIT;
            end else if (ex_redirect) begin
                ctl.pc_en      = 1'b1;
                ctl.ifid_en    = 1'b1;
                ctl.idex_en    = 1'b1;
                ctl.exmem_en   = 1'b1;
                ctl.memwb_en   = 1'b1;
                ctl.ifid_flush = 1'b1;
                ctl.idex_flush = 1'b1;
                act_redirect   = 1'b1;
            end else if (load_use) begin
                ctl.idex_flush = 1'b1;
                ctl.exmem_en   = 1'b1;
                ctl.memwb_en   = 1'b1;
            end else if (!ihit) begin
                ctl.ifid_flush = 1'b1;
                ctl.idex_en    = 1'b1;
                ctl.exmem_en   = 1'b1;
                ctl.memwb_en   = 1'b1;
            end else begin
                ctl.pc_en    = 1'b1;
                ctl.ifid_en  = 1'b1;
                ctl.idex_en  = 1'b1;
                ctl.exmem_en = 1'b1;
                ctl.memwb_en = 1'b1;
            end
        end
    end

    assign pc_en       = ctl.pc_en;
    assign ifid_en     = ctl.ifid_en;
    assign idex_en     = ctl.idex_en;
    assign exmem_en    = ctl.exmem_en;
    assign memwb_en    = ctl.memwb_en;
    assign ifid_flush  = ctl.ifid_flush;
    assign idex_flush  = ctl.idex_flush;
    assign exmem_flush = ctl.exmem_flush;
    assign memwb_flush = ctl.memwb_flush;

`ifdef PIPELINE_CTRL_PERF_EN
    // Counters wrap naturally at CNT_W bits
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (((state == RUN) || (state == MEM_WAIT)) && !ctl.pc_en)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (act_redirect)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_act_redirect;
    assign unused_act_redirect = act_redirect;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: default instance plus a short-timeout instance on shared stimulus.
module tb_pipeline_ctrl;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       ihit, dhit, mem_dreq, mem_halt, ex_load, id_uses_rt, ex_redirect;
    logic [4:0] ex_wsel, id_rs, id_rt;

    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halted, mem_timeout;
    logic pc_en2, ifid_en2, idex_en2, exmem_en2, memwb_en2;
    logic ifid_flush2, idex_flush2, exmem_flush2, memwb_flush2, halted2, mem_timeout2;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt, stall_cnt2, flush_cnt2;
`endif

    logic [31:0] en_v, fl_v;
    int checks = 0;
    int errors = 0;

    assign en_v = {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    assign fl_v = {28'd0, ifid_flush, idex_flush, exmem_flush, memwb_flush};

    always #5 CLK = ~CLK;

    pipeline_ctrl u_dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
        .mem_halt(mem_halt), .ex_load(ex_load), .ex_wsel(ex_wsel), .id_rs(id_rs),
        .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_redirect(ex_redirect),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halted(halted),
        .mem_timeout(mem_timeout)
`ifdef PIPELINE_CTRL_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    pipeline_ctrl #(.DMEM_TIMEOUT(2)) u_dut2 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
        .mem_halt(mem_halt), .ex_load(ex_load), .ex_wsel(ex_wsel), .id_rs(id_rs),
        .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_redirect(ex_redirect),
        .pc_en(pc_en2), .ifid_en(ifid_en2), .idex_en(idex_en2), .exmem_en(exmem_en2),
        .memwb_en(memwb_en2), .ifid_flush(ifid_flush2), .idex_flush(idex_flush2),
        .exmem_flush(exmem_flush2), .memwb_flush(memwb_flush2), .halted(halted2),
        .mem_timeout(mem_timeout2)
`ifdef PIPELINE_CTRL_PERF_EN
        , .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; mem_dreq = 1'b0; mem_halt = 1'b0;
        ex_load = 1'b0; ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        id_uses_rt = 1'b0; ex_redirect = 1'b0;
    endtask

    // Advance to the next cycle's drive point (mid-low phase, away from the rising edge)
    task automatic next();
        @(negedge CLK);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        nRST = 1'b0;
        next(); settle();
        check("reset_en", en_v, 32'h00);
        check("reset_fl", fl_v, 32'h0);
        check("reset_halted", {31'd0, halted}, 32'd0);
        check("reset_timeout", {31'd0, mem_timeout}, 32'd0);

        // START cycle after release, then RUN
        nRST = 1'b1; settle();
        check("start_en", en_v, 32'h00);
        next(); settle();
        check("run_en", en_v, 32'h1F);
        check("run_fl", fl_v, 32'h0);

        // Load-use on rs
        next(); ex_load = 1'b1; ex_wsel = 5'd5; id_rs = 5'd5; settle();
        check("lu_rs_en", en_v, 32'h03);
        check("lu_rs_fl", fl_v, 32'h4);
        next(); ex_wsel = 5'd0; id_rs = 5'd0; settle();
        check("lu_r0_en", en_v, 32'h1F);
        check("lu_r0_fl", fl_v, 32'h0);
        next(); ex_wsel = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; settle();
        check("lu_rt_en", en_v, 32'h03);
        next(); id_uses_rt = 1'b0; settle();
        check("lu_rt_unused_en", en_v, 32'h1F);

        // Fetch miss
        next(); idle(); ihit = 1'b0; settle();
        check("imiss_en", en_v, 32'h07);
        check("imiss_fl", fl_v, 32'h8);

        // Redirect beats load-use and fetch miss
        next(); ex_redirect = 1'b1; ex_load = 1'b1; ex_wsel = 5'd5; id_rs = 5'd5; settle();
        check("redir_en", en_v, 32'h1F);
        check("redir_fl", fl_v, 32'hC);

        // Data miss: 3 frozen cycles, then hit
        next(); idle(); mem_dreq = 1'b1; settle();
        check("dmiss1_en", en_v, 32'h00);
        check("dmiss1_fl", fl_v, 32'h1);
        next(); settle();
        check("dmiss2_en", en_v, 32'h00);
        check("dmiss2_fl", fl_v, 32'h1);
        next(); settle();
        check("dmiss3_en", en_v, 32'h00);
        check("dmiss3_to2", {31'd0, mem_timeout2}, 32'd0);
        next(); dhit = 1'b1; settle();
        check("dhit_en", en_v, 32'h1F);
        check("dhit_fl", fl_v, 32'h0);
        check("dhit_to2", {31'd0, mem_timeout2}, 32'd1);
        check("dhit_to1", {31'd0, mem_timeout}, 32'd0);
        next(); idle(); settle();
        check("after_wait_en", en_v, 32'h1F);
        check("to2_sticky", {31'd0, mem_timeout2}, 32'd1);

        // Halt held off by an outstanding data miss; skipped on the hit cycle
        next(); mem_halt = 1'b1; mem_dreq = 1'b1; settle();
        check("halt_miss_en", en_v, 32'h00);
        check("halt_miss_fl", fl_v, 32'h1);
        next(); dhit = 1'b1; settle();
        check("halt_skip_en", en_v, 32'h1F);

        // Halt: RUN detect, HALT_DRAIN, then HALTED
        next(); mem_dreq = 1'b0; dhit = 1'b0; settle();
        check("halt_run_en", en_v, 32'h01);
        check("halt_run_fl", fl_v, 32'hE);
        next(); mem_halt = 1'b0; settle();
        check("drain_en", en_v, 32'h01);
        check("drain_fl", fl_v, 32'hE);
        check("drain_halted", {31'd0, halted}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            next(); settle();
            check("halted_en", en_v, 32'h00);
            check("halted_fl", fl_v, 32'h0);
            check("halted_flag", {31'd0, halted}, 32'd1);
        end
        check("halted_to2", {31'd0, mem_timeout2}, 32'd1);

        // Async reset mid-HALTED
        #2 nRST = 1'b0; settle();
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_to2", {31'd0, mem_timeout2}, 32'd0);
        check("rst_en", en_v, 32'h00);

`ifdef PIPELINE_CTRL_PERF_EN
        check("rst_stall_cnt", stall_cnt, 32'd0);
        next(); nRST = 1'b1; settle();
        next(); ex_load = 1'b1; ex_wsel = 5'd3; id_rs = 5'd3; settle();
        next(); settle();
        next(); ex_redirect = 1'b1; settle();
        next(); idle(); settle();
        check("perf_stall_cnt", stall_cnt, 32'd2);
        check("perf_flush_cnt", flush_cnt, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
